// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared states and segment patterns for the 2-digit 7-segment mux driver
package seg7_pkg;

    typedef enum logic [1:0] {
        S_TENS  = 2'd0,
        S_GAP1  = 2'd1,
        S_UNITS = 2'd2,
        S_GAP2  = 2'd3
    } state_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF  = 7'h00;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] DIG_0    = 7'h3F;
    localparam logic [6:0] DIG_1    = 7'h06;
    localparam logic [6:0] DIG_2    = 7'h5B;
    localparam logic [6:0] DIG_3    = 7'h4F;
    localparam logic [6:0] DIG_4    = 7'h66;
    localparam logic [6:0] DIG_5    = 7'h6D;
    localparam logic [6:0] DIG_6    = 7'h7D;
    localparam logic [6:0] DIG_7    = 7'h07;
    localparam logic [6:0] DIG_8    = 7'h7F;
    localparam logic [6:0] DIG_9    = 7'h6F;

endpackage

// File: rtl/seg7_mux_driver_bcd_to_seg7.sv
// rtl/seg7_mux_driver_bcd_to_seg7.sv - combinational BCD to active-high 7-segment decoder
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0: pattern = DIG_0;
            4'd1: pattern = DIG_1;
            4'd2: pattern = DIG_2;
            4'd3: pattern = DIG_3;
            4'd4: pattern = DIG_4;
            4'd5: pattern = DIG_5;
            4'd6: pattern = DIG_6;
            4'd7: pattern = DIG_7;
            4'd8: pattern = DIG_8;
            4'd9: pattern = DIG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// rtl/seg7_mux_driver.sv - 2-digit multiplexed 7-segment driver with dead time and per-frame digit latch
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 4,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] chuc,
    input  logic [3:0] donvi,
    input  logic       blank_lead,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int MAX_LEN = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] REF_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
    localparam logic [6:0]    SEG_POL   = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    AN_POL    = ACTIVE_LOW ? 2'b11 : 2'b00;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_last;
    logic [3:0]    shadow_tens, shadow_units;
    logic [3:0]    eff_tens, eff_units, dec_in;
    logic [6:0]    dec_pat, seg_nxt;
    logic [1:0]    an_nxt;
    logic          latch_now;

    assign latch_now = (state == S_TENS) && (cnt == '0);

    // On the latch edge the shadow still holds last frame's digits, so show what is being captured
    assign eff_tens  = latch_now ? chuc  : shadow_tens;
    assign eff_units = latch_now ? donvi : shadow_units;
    assign dec_in    = (state == S_UNITS) ? eff_units : eff_tens;

    bcd_to_seg7 u_dec (
        .bcd     (dec_in),
        .pattern (dec_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_TENS;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        cnt_last  = ((state == S_TENS) || (state == S_UNITS)) ? REF_LAST : DEAD_LAST;
        if (cnt == cnt_last) begin
            cnt_nxt = '0;
            case (state)
                S_TENS:  state_nxt = S_GAP1;
                S_GAP1:  state_nxt = S_UNITS;
                S_UNITS: state_nxt = S_GAP2;
                S_GAP2:  state_nxt = S_TENS;
                default: state_nxt = S_TENS;
            endcase
        end
    end

    always_comb begin
        an_nxt  = 2'b00;
        seg_nxt = SEG_OFF;
        case (state)
            S_TENS: begin
                seg_nxt = dec_pat;
                an_nxt  = (blank_lead && (eff_tens == 4'd0)) ? 2'b00 : 2'b10;
            end
            S_UNITS: begin
                seg_nxt = dec_pat;
                an_nxt  = 2'b01;
            end
            default: begin
                an_nxt  = 2'b00;
                seg_nxt = SEG_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_tens  <= 4'd0;
            shadow_units <= 4'd0;
        end else if (latch_now) begin
            shadow_tens  <= chuc;
            shadow_units <= donvi;
        end
    end

    // Polarity is folded in here so "off" is a single XOR constant for both reset and gaps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_POL;
            an  <= AN_POL;
        end else begin
            seg <= seg_nxt ^ SEG_POL;
            an  <= an_nxt ^ AN_POL;
        end
    end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// tb/tb_seg7_mux_driver.sv - self-checking bench for seg7_mux_driver (both polarities)
module tb_seg7_mux_driver;

    localparam int R     = 4;
    localparam int D     = 2;
    localparam int FRAME = 2 * (R + D);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] chuc = 4'd0;
    logic [3:0] donvi = 4'd0;
    logic       blank_lead = 1'b0;
    logic [6:0] seg_h, seg_l;
    logic [1:0] an_h, an_l;

    seg7_mux_driver #(.REFRESH_DIV(R), .DEAD_CYC(D), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .chuc(chuc), .donvi(donvi),
        .blank_lead(blank_lead), .seg(seg_h), .an(an_h)
    );

    seg7_mux_driver #(.REFRESH_DIV(R), .DEAD_CYC(D), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .chuc(chuc), .donvi(donvi),
        .blank_lead(blank_lead), .seg(seg_l), .an(an_l)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_dec(input logic [3:0] d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (d > 4'd9) return 7'h40;
        return tbl[d];
    endfunction

    // Reference: a single frame position 0..FRAME-1, carved into tens/gap/units/gap windows
    function automatic logic [1:0] model_an(input int pos, input logic [3:0] t, input logic blank);
        if (pos < R) return (blank && t == 4'd0) ? 2'b00 : 2'b10;
        if (pos < R + D) return 2'b00;
        if (pos < 2 * R + D) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [6:0] model_seg(input int pos, input logic [3:0] t, input logic [3:0] u);
        if (pos < R) return ref_dec(t);
        if (pos < R + D) return 7'h00;
        if (pos < 2 * R + D) return ref_dec(u);
        return 7'h00;
    endfunction

    int         pos;
    logic [3:0] m_t, m_u;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos     <= 0;
            m_t     <= 4'd0;
            m_u     <= 4'd0;
            exp_an  <= 2'b00;
            exp_seg <= 7'h00;
        end else begin
            if (pos == 0) begin
                m_t <= chuc;
                m_u <= donvi;
            end
            pos     <= (pos == FRAME - 1) ? 0 : pos + 1;
            exp_an  <= model_an(pos, (pos == 0) ? chuc : m_t, blank_lead);
            exp_seg <= model_seg(pos, (pos == 0) ? chuc : m_t, (pos == 0) ? donvi : m_u);
        end
    end

    bit live_check = 1'b0;

    always @(negedge clk) begin
        if (live_check) begin
            check("live_seg_h", {1'b0, seg_h}, {1'b0, exp_seg});
            check("live_an_h", {6'b0, an_h}, {6'b0, exp_an});
            check("live_seg_l", {1'b0, seg_l}, {1'b0, ~exp_seg});
            check("live_an_l", {6'b0, an_l}, {6'b0, ~exp_an});
            check("no_double_h", {7'b0, an_h != 2'b11}, 8'd1);
            check("no_double_l", {7'b0, an_l != 2'b00}, 8'd1);
        end
    end

    typedef struct {
        logic [3:0] c;
        logic [3:0] u;
        logic       b;
        logic [6:0] t_seg;
        logic [1:0] t_an;
        logic [6:0] u_seg;
    } vec_t;

    vec_t vecs [6];

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{4'd3, 4'd7, 1'b0, 7'h4F, 2'b10, 7'h07};
        vecs[1] = '{4'd0, 4'd4, 1'b1, 7'h3F, 2'b00, 7'h66};
        vecs[2] = '{4'd2, 4'd4, 1'b1, 7'h5B, 2'b10, 7'h66};
        vecs[3] = '{4'hC, 4'hF, 1'b0, 7'h40, 2'b10, 7'h40};
        vecs[4] = '{4'd1, 4'd8, 1'b0, 7'h06, 2'b10, 7'h7F};
        vecs[5] = '{4'd5, 4'd9, 1'b0, 7'h6D, 2'b10, 7'h6F};

        chuc  = 4'd3;
        donvi = 4'd7;
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_seg_h", {1'b0, seg_h}, 8'h00);
        check("reset_an_h", {6'b0, an_h}, 8'h00);
        check("reset_seg_l", {1'b0, seg_l}, 8'h7F);
        check("reset_an_l", {6'b0, an_l}, 8'h03);
        live_check = 1'b1;

        for (int i = 0; i < 6; i++) begin
            chuc       = vecs[i].c;
            donvi      = vecs[i].u;
            blank_lead = vecs[i].b;
            restart();
            repeat (2) @(negedge clk);
            check("vec_tens_seg", {1'b0, seg_h}, {1'b0, vecs[i].t_seg});
            check("vec_tens_an", {6'b0, an_h}, {6'b0, vecs[i].t_an});
            check("vec_tens_seg_l", {1'b0, seg_l}, {1'b0, ~vecs[i].t_seg});
            check("vec_tens_an_l", {6'b0, an_l}, {6'b0, ~vecs[i].t_an});
            repeat (3) @(negedge clk);
            check("vec_gap_an", {6'b0, an_h}, 8'h00);
            check("vec_gap_seg", {1'b0, seg_h}, 8'h00);
            check("vec_gap_seg_l", {1'b0, seg_l}, 8'h7F);
            repeat (3) @(negedge clk);
            check("vec_units_seg", {1'b0, seg_h}, {1'b0, vecs[i].u_seg});
            check("vec_units_an", {6'b0, an_h}, 8'h01);
            check("vec_units_seg_l", {1'b0, seg_l}, {1'b0, ~vecs[i].u_seg});
            check("vec_units_an_l", {6'b0, an_l}, 8'h02);
        end

        // Input change mid-units must not tear the current frame
        blank_lead = 1'b0;
        chuc       = 4'd5;
        donvi      = 4'd9;
        restart();
        repeat (8) @(negedge clk);
        chuc  = 4'd0;
        donvi = 4'd0;
        @(negedge clk);
        check("torn_units_seg", {1'b0, seg_h}, 8'h6F);
        check("torn_units_an", {6'b0, an_h}, 8'h01);
        repeat (5) @(negedge clk);
        check("next_tens_seg", {1'b0, seg_h}, 8'h3F);
        check("next_tens_an", {6'b0, an_h}, 8'h02);
        repeat (6) @(negedge clk);
        check("next_units_seg", {1'b0, seg_h}, 8'h3F);

        // Asynchronous reset in the middle of the units slot
        chuc  = 4'd1;
        donvi = 4'd2;
        restart();
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_an_h", {6'b0, an_h}, 8'h00);
        check("async_seg_h", {1'b0, seg_h}, 8'h00);
        check("async_an_l", {6'b0, an_l}, 8'h03);
        check("async_seg_l", {1'b0, seg_l}, 8'h7F);
        chuc  = 4'd6;
        donvi = 4'd3;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tens_seg", {1'b0, seg_h}, 8'h7D);
        check("post_rst_tens_an", {6'b0, an_h}, 8'h02);
        repeat (6) @(negedge clk);
        check("post_rst_units_seg", {1'b0, seg_h}, 8'h4F);

        // Randomized inputs and occasional resets against the frame-position model
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                chuc  = 4'($urandom_range(0, 15));
                donvi = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 9) == 0) blank_lead = ~blank_lead;
            if ($urandom_range(0, 4) == 0) chuc = 4'd0;
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        live_check = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
